// File: rtl/menu_pkg.sv
// Shared constants and types for the menu navigation controller.
// The mode constants double as the two states of the top-level mode FSM.
package menu_pkg;

    localparam logic [0:0] MODE_MENU   = 1'b0;
    localparam logic [0:0] MODE_ACTIVE = 1'b1;

    // Cursor move requests issued by the mode FSM to the cursor register.
    typedef enum logic [1:0] {
        MOVE_NONE = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        MOVE_HOME = 2'd3
    } menu_move_e;

endpackage

// File: rtl/menu_nav_ctrl_if.sv
// Bundle between the one-shot key decoder (master) and the menu controller (slave).
// Protocol: arrow_up/arrow_down/enter/esc are single-cycle pulses sampled on the
// rising clock edge; there is no back-pressure, every pulse is consumed on the
// edge it is present. The controller answers on that same edge with registered
// mode/cursor/active_item and single-cycle enter_pulse/exit_pulse strobes.
interface menu_nav_ctrl_if #(
    parameter int CUR_W = 1
);
    logic             arrow_up;
    logic             arrow_down;
    logic             enter;
    logic             esc;
    logic             mode;
    logic [CUR_W-1:0] cursor;
    logic [CUR_W-1:0] active_item;
    logic             enter_pulse;
    logic             exit_pulse;

    modport master (
        output arrow_up, arrow_down, enter, esc,
        input  mode, cursor, active_item, enter_pulse, exit_pulse
    );

    modport slave (
        input  arrow_up, arrow_down, enter, esc,
        output mode, cursor, active_item, enter_pulse, exit_pulse
    );
endinterface

// File: rtl/menu_cursor.sv
// Up/down/home cursor register over N_ITEMS entries.
// Build option: define MENU_WRAP_EN to wrap at both ends; otherwise the cursor
// saturates at 0 and N_ITEMS-1.
module menu_cursor
    import menu_pkg::*;
#(
    parameter int N_ITEMS = 2,
    parameter int CUR_W   = $clog2(N_ITEMS)
) (
    input  logic             clk,
    input  logic             reset,
    input  menu_move_e       move,
    output logic [CUR_W-1:0] cursor
);

    // Explicit top index so non-power-of-2 item counts never reach unused codes.
    localparam logic [CUR_W-1:0] MAX_IDX = CUR_W'(N_ITEMS - 1);

    logic [CUR_W-1:0] cursor_q;
    logic [CUR_W-1:0] cursor_d;

    // Next cursor value from the requested move, applying the boundary policy.
    always_comb begin
        cursor_d = cursor_q;
        case (move)
            MOVE_UP: begin
                if (cursor_q == '0) begin
`ifdef MENU_WRAP_EN
                    cursor_d = MAX_IDX;
`else
                    cursor_d = cursor_q;
`endif
                end else begin
                    cursor_d = cursor_q - CUR_W'(1);
                end
            end
            MOVE_DOWN: begin
                if (cursor_q == MAX_IDX) begin
`ifdef MENU_WRAP_EN
                    cursor_d = '0;
`else
                    cursor_d = cursor_q;
`endif
                end else begin
                    cursor_d = cursor_q + CUR_W'(1);
                end
            end
            MOVE_HOME: cursor_d = '0;
            default:   cursor_d = cursor_q;
        endcase
    end

    // Cursor register, cleared asynchronously to the home item.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cursor_q <= '0;
        end else begin
            cursor_q <= cursor_d;
        end
    end

    assign cursor = cursor_q;

endmodule

// File: rtl/menu_nav_ctrl.sv
// Menu navigation controller: MENU/ACTIVE mode FSM, per-item escape lock,
// idle-timeout cursor homing and enter/exit strobes. Cursor boundary handling
// lives in menu_cursor and follows the MENU_WRAP_EN build option.
module menu_nav_ctrl
    import menu_pkg::*;
#(
    parameter int                 N_ITEMS     = 2,
    parameter int                 CUR_W       = $clog2(N_ITEMS),
    parameter logic [N_ITEMS-1:0] LOCK_MASK   = 2'b01,
    parameter int                 IDLE_CYCLES = 0,
    parameter int                 IDLE_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    menu_nav_ctrl_if.slave bus
);

    // Lock mask padded to every cursor code so indexing by item never goes out of range.
    localparam int                LOCK_W   = 2 ** CUR_W;
    localparam logic [LOCK_W-1:0] LOCK_VEC = LOCK_W'(LOCK_MASK);
    // Counter value on which the idle timeout fires (unused when the timeout is off).
    localparam logic [IDLE_W-1:0] IDLE_LAST = (IDLE_CYCLES > 0) ? IDLE_W'(IDLE_CYCLES - 1) : '0;

    logic [0:0]       mode_q, mode_d;
    logic [CUR_W-1:0] active_q, active_d;
    logic             enter_pulse_q, enter_pulse_d;
    logic             exit_pulse_q, exit_pulse_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CUR_W-1:0] cursor_q;
    menu_move_e       move;
    logic             any_pulse;

    assign any_pulse = bus.arrow_up | bus.arrow_down | bus.enter | bus.esc;

    // Mode FSM, cursor move selection, idle counter and strobe generation.
    always_comb begin
        mode_d        = mode_q;
        active_d      = active_q;
        enter_pulse_d = 1'b0;
        exit_pulse_d  = 1'b0;
        idle_d        = idle_q;
        move          = MOVE_NONE;
        if (mode_q == MODE_MENU) begin
            // Enter wins over everything and latches the pre-edge cursor.
            if (bus.enter) begin
                mode_d        = MODE_ACTIVE;
                active_d      = cursor_q;
                enter_pulse_d = 1'b1;
            end else if (bus.esc) begin
                move = MOVE_HOME;
            end else if (bus.arrow_up && !bus.arrow_down) begin
                move = MOVE_UP;
            end else if (bus.arrow_down && !bus.arrow_up) begin
                move = MOVE_DOWN;
            end
            // Any pulse restarts the idle count, even one that does not move the cursor.
            if (any_pulse) begin
                idle_d = '0;
            end else if ((IDLE_CYCLES > 0) && (idle_q == IDLE_LAST)) begin
                idle_d = '0;
                move   = MOVE_HOME;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end else begin
            // Cursor stays frozen at active_item, so leaving restores the highlight.
            idle_d = '0;
            if (bus.esc && !LOCK_VEC[active_q]) begin
                mode_d       = MODE_MENU;
                exit_pulse_d = 1'b1;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q        <= MODE_MENU;
            active_q      <= '0;
            enter_pulse_q <= 1'b0;
            exit_pulse_q  <= 1'b0;
            idle_q        <= '0;
        end else begin
            mode_q        <= mode_d;
            active_q      <= active_d;
            enter_pulse_q <= enter_pulse_d;
            exit_pulse_q  <= exit_pulse_d;
            idle_q        <= idle_d;
        end
    end

    menu_cursor #(
        .N_ITEMS (N_ITEMS),
        .CUR_W   (CUR_W)
    ) u_cursor (
        .clk    (clk),
        .reset  (reset),
        .move   (move),
        .cursor (cursor_q)
    );

    assign bus.mode        = mode_q;
    assign bus.cursor      = cursor_q;
    assign bus.active_item = active_q;
    assign bus.enter_pulse = enter_pulse_q;
    assign bus.exit_pulse  = exit_pulse_q;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Directed bench for menu_nav_ctrl. Two instances with N_ITEMS=4 and
// LOCK_MASK=4'b0001 share the stimulus: dut_a has the idle timeout off,
// dut_b uses IDLE_CYCLES=8. Expected boundary values follow MENU_WRAP_EN.
module tb_menu_nav_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic up = 1'b0, down = 1'b0, ent = 1'b0, esc = 1'b0;
    int   n_checks = 0;
    int   n_bad = 0;

`ifdef MENU_WRAP_EN
    localparam logic [1:0] EXP_DOWN_TOP = 2'd0;
    localparam logic [1:0] EXP_UP_BOT   = 2'd3;
    localparam logic [1:0] EXP_A_IDLE   = 2'd1;
`else
    localparam logic [1:0] EXP_DOWN_TOP = 2'd3;
    localparam logic [1:0] EXP_UP_BOT   = 2'd0;
    localparam logic [1:0] EXP_A_IDLE   = 2'd2;
`endif

    menu_nav_ctrl_if #(.CUR_W(2)) if_a ();
    menu_nav_ctrl_if #(.CUR_W(2)) if_b ();

    assign if_a.arrow_up = up;  assign if_a.arrow_down = down;
    assign if_a.enter    = ent; assign if_a.esc        = esc;
    assign if_b.arrow_up = up;  assign if_b.arrow_down = down;
    assign if_b.enter    = ent; assign if_b.esc        = esc;

    menu_nav_ctrl #(.N_ITEMS(4), .CUR_W(2), .LOCK_MASK(4'b0001), .IDLE_CYCLES(0), .IDLE_W(32))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    menu_nav_ctrl #(.N_ITEMS(4), .CUR_W(2), .LOCK_MASK(4'b0001), .IDLE_CYCLES(8), .IDLE_W(32))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));

    // Clock
    always #5 clk = ~clk;

    // One-cycle pulse on the chosen inputs; returns 1 time unit after the edge.
    task automatic step(input logic u, input logic d, input logic e, input logic x);
        @(negedge clk);
        up = u; down = d; ent = e; esc = x;
        @(posedge clk);
        #1;
        up = 1'b0; down = 1'b0; ent = 1'b0; esc = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++; if (if_a.mode !== 1'b0) begin $display("FAIL reset_mode got=%0d exp=0", if_a.mode); n_bad++; end
        n_checks++; if (if_a.cursor !== 2'd0) begin $display("FAIL reset_cursor got=%0d exp=0", if_a.cursor); n_bad++; end
        n_checks++; if (if_a.active_item !== 2'd0) begin $display("FAIL reset_active got=%0d exp=0", if_a.active_item); n_bad++; end
        n_checks++; if ({if_a.enter_pulse, if_a.exit_pulse} !== 2'b00) begin $display("FAIL reset_pulses got=%b exp=00", {if_a.enter_pulse, if_a.exit_pulse}); n_bad++; end
        n_checks++; if ({if_b.mode, if_b.cursor} !== 3'b000) begin $display("FAIL reset_b got=%b exp=000", {if_b.mode, if_b.cursor}); n_bad++; end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_nav();
        step(0, 1, 0, 0);
        n_checks++; if (if_a.cursor !== 2'd1) begin $display("FAIL nav_down1 got=%0d exp=1", if_a.cursor); n_bad++; end
        step(0, 1, 0, 0);
        n_checks++; if (if_a.cursor !== 2'd2) begin $display("FAIL nav_down2 got=%0d exp=2", if_a.cursor); n_bad++; end
        step(0, 1, 0, 0);
        n_checks++; if (if_a.cursor !== 2'd3) begin $display("FAIL nav_down3 got=%0d exp=3", if_a.cursor); n_bad++; end
        step(0, 1, 0, 0);
        n_checks++; if (if_a.cursor !== EXP_DOWN_TOP) begin $display("FAIL nav_down_top got=%0d exp=%0d", if_a.cursor, EXP_DOWN_TOP); n_bad++; end
        step(0, 0, 0, 1);
        n_checks++; if (if_a.cursor !== 2'd0) begin $display("FAIL nav_esc_home got=%0d exp=0", if_a.cursor); n_bad++; end
        step(1, 0, 0, 0);
        n_checks++; if (if_a.cursor !== EXP_UP_BOT) begin $display("FAIL nav_up_bot got=%0d exp=%0d", if_a.cursor, EXP_UP_BOT); n_bad++; end
        step(0, 0, 0, 1);
        n_checks++; if (if_a.mode !== 1'b0 || if_a.cursor !== 2'd0) begin $display("FAIL nav_home2 got=%0d/%0d exp=0/0", if_a.mode, if_a.cursor); n_bad++; end
    endtask

    task automatic test_enter();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        n_checks++; if (if_a.cursor !== 2'd2) begin $display("FAIL ent_pre_cursor got=%0d exp=2", if_a.cursor); n_bad++; end
        step(0, 0, 1, 0);
        n_checks++; if (if_a.mode !== 1'b1) begin $display("FAIL ent_mode got=%0d exp=1", if_a.mode); n_bad++; end
        n_checks++; if (if_a.active_item !== 2'd2) begin $display("FAIL ent_active got=%0d exp=2", if_a.active_item); n_bad++; end
        n_checks++; if ({if_a.enter_pulse, if_a.exit_pulse} !== 2'b10) begin $display("FAIL ent_pulse got=%b exp=10", {if_a.enter_pulse, if_a.exit_pulse}); n_bad++; end
        idle(1);
        n_checks++; if (if_a.enter_pulse !== 1'b0) begin $display("FAIL ent_pulse_drop got=%0d exp=0", if_a.enter_pulse); n_bad++; end
        step(1, 0, 0, 0);
        n_checks++; if (if_a.cursor !== 2'd2 || if_a.mode !== 1'b1) begin $display("FAIL ent_frozen got=%0d/%0d exp=2/1", if_a.cursor, if_a.mode); n_bad++; end
        step(0, 0, 1, 0);
        n_checks++; if (if_a.enter_pulse !== 1'b0 || if_a.active_item !== 2'd2) begin $display("FAIL ent_ignored got=%0d/%0d exp=0/2", if_a.enter_pulse, if_a.active_item); n_bad++; end
        step(0, 0, 0, 1);
        n_checks++; if (if_a.mode !== 1'b0 || if_a.cursor !== 2'd2) begin $display("FAIL exit_state got=%0d/%0d exp=0/2", if_a.mode, if_a.cursor); n_bad++; end
        n_checks++; if ({if_a.enter_pulse, if_a.exit_pulse} !== 2'b01) begin $display("FAIL exit_pulse got=%b exp=01", {if_a.enter_pulse, if_a.exit_pulse}); n_bad++; end
        idle(1);
        n_checks++; if (if_a.exit_pulse !== 1'b0) begin $display("FAIL exit_pulse_drop got=%0d exp=0", if_a.exit_pulse); n_bad++; end
    endtask

    task automatic test_lock();
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        n_checks++; if (if_a.mode !== 1'b1 || if_a.active_item !== 2'd0) begin $display("FAIL lock_enter got=%0d/%0d exp=1/0", if_a.mode, if_a.active_item); n_bad++; end
        step(0, 0, 0, 1);
        n_checks++; if (if_a.mode !== 1'b1 || if_a.exit_pulse !== 1'b0) begin $display("FAIL lock_esc got=%0d/%0d exp=1/0", if_a.mode, if_a.exit_pulse); n_bad++; end
        do_reset();
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        n_checks++; if (if_a.active_item !== 2'd1) begin $display("FAIL unlock_enter got=%0d exp=1", if_a.active_item); n_bad++; end
        step(0, 0, 0, 1);
        n_checks++; if (if_a.mode !== 1'b0 || if_a.cursor !== 2'd1 || if_a.exit_pulse !== 1'b1) begin $display("FAIL unlock_esc got=%0d/%0d/%0d exp=0/1/1", if_a.mode, if_a.cursor, if_a.exit_pulse); n_bad++; end
        idle(1);
        n_checks++; if (if_a.exit_pulse !== 1'b0) begin $display("FAIL unlock_pulse_drop got=%0d exp=0", if_a.exit_pulse); n_bad++; end
    endtask

    task automatic test_same_cycle();
        step(0, 1, 1, 0);
        n_checks++; if (if_a.mode !== 1'b1 || if_a.active_item !== 2'd1 || if_a.cursor !== 2'd1) begin $display("FAIL same_enter_down got=%0d/%0d/%0d exp=1/1/1", if_a.mode, if_a.active_item, if_a.cursor); n_bad++; end
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        n_checks++; if (if_a.mode !== 1'b0 || if_a.cursor !== 2'd1) begin $display("FAIL same_up_down got=%0d/%0d exp=0/1", if_a.mode, if_a.cursor); n_bad++; end
        step(0, 1, 0, 1);
        n_checks++; if (if_a.cursor !== 2'd0) begin $display("FAIL same_esc_down got=%0d exp=0", if_a.cursor); n_bad++; end
    endtask

    task automatic test_idle();
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        n_checks++; if (if_b.cursor !== 2'd3) begin $display("FAIL idle_pre got=%0d exp=3", if_b.cursor); n_bad++; end
        idle(7);
        n_checks++; if (if_b.cursor !== 2'd3) begin $display("FAIL idle_7 got=%0d exp=3", if_b.cursor); n_bad++; end
        idle(1);
        n_checks++; if (if_b.cursor !== 2'd0) begin $display("FAIL idle_8 got=%0d exp=0", if_b.cursor); n_bad++; end
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        idle(4);
        step(1, 0, 0, 0);
        n_checks++; if (if_b.cursor !== 2'd2) begin $display("FAIL idle_restart_arrow got=%0d exp=2", if_b.cursor); n_bad++; end
        idle(7);
        n_checks++; if (if_b.cursor !== 2'd2) begin $display("FAIL idle_restart_7 got=%0d exp=2", if_b.cursor); n_bad++; end
        idle(1);
        n_checks++; if (if_b.cursor !== 2'd0) begin $display("FAIL idle_restart_8 got=%0d exp=0", if_b.cursor); n_bad++; end
        n_checks++; if (if_a.cursor !== EXP_A_IDLE) begin $display("FAIL idle_disabled got=%0d exp=%0d", if_a.cursor, EXP_A_IDLE); n_bad++; end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        n_checks++; if (if_a.mode !== 1'b1 || if_a.active_item !== 2'd2) begin $display("FAIL areset_pre got=%0d/%0d exp=1/2", if_a.mode, if_a.active_item); n_bad++; end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({if_a.mode, if_a.cursor, if_a.active_item, if_a.enter_pulse, if_a.exit_pulse} !== 7'b0) begin
            $display("FAIL areset_async got=%b exp=0000000", {if_a.mode, if_a.cursor, if_a.active_item, if_a.enter_pulse, if_a.exit_pulse}); n_bad++; end
        @(negedge clk); reset = 1'b1;
        idle(1);
        n_checks++; if (if_a.mode !== 1'b0 || if_a.cursor !== 2'd0) begin $display("FAIL areset_release got=%0d/%0d exp=0/0", if_a.mode, if_a.cursor); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_nav();
        test_enter();
        test_lock();
        test_same_cycle();
        test_idle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
